pipe_hazard_ctrl: RTL and testbench

- Parametrised control plane for an in-order scalar pipeline: valid/allowin chain over STAGES post-issue stages plus a destination-tag scoreboard.
- Generates per-stage load enables, operand forward selects and the load-use interlock for the instruction in decode.
- Generalises the fixed 5-stage handshake and the two-source forward logic of the current core to arbitrary depth, adds per-stage squash and occupancy reporting.
- Datapath registers stay outside the block and load on stage_adv.

---
 rtl/pipe_hazard_ctrl.sv | 89 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: valid/allowin pipeline control with tag scoreboard forwarding and load-use interlock
module pipe_hazard_ctrl #(
  parameter int STAGES = 3,
  parameter int REG_W = 5,
  parameter int NSRC = 2,
  parameter int LOAD_READY_STAGE = 2,
  parameter int FW = $clog2(STAGES + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_allowin,
  input  logic [REG_W-1:0]        in_dst,
  input  logic                    in_we,
  input  logic                    in_is_load,
  input  logic [NSRC*REG_W-1:0]   in_src,
  input  logic [NSRC-1:0]         in_src_used,
  input  logic [STAGES-1:0]       stage_ready_go,
  input  logic [STAGES-1:0]       flush,
  input  logic                    out_allowin,
  output logic [STAGES-1:0]       stage_adv,
  output logic [STAGES-1:0]       stage_valid,
  output logic [STAGES*REG_W-1:0] stage_dst,
  output logic [STAGES-1:0]       stage_we,
  output logic [NSRC*FW-1:0]      fwd_sel,
  output logic                    stall,
  output logic                    retire_valid,
  output logic [FW-1:0]           occupancy
);
  logic [STAGES-1:0] valid, we_q, ld_q, allowin, to_valid;
  logic [REG_W-1:0]  dst_q [STAGES];
  // Back-pressure ripples from the sink toward issue; a squashed or empty stage always accepts
  always_comb begin : allow_chain
    logic nxt;
    nxt = out_allowin;
    allowin = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      nxt = !valid[i] || flush[i] || (stage_ready_go[i] && nxt);
      allowin[i] = nxt;
    end
  end
  // Youngest matching producer wins; a not-yet-ready load blocks issue instead of forwarding
  always_comb begin : fwd_scan
    logic hit;
    logic [REG_W-1:0] src;
    stall = 1'b0;
    fwd_sel = '0;
    for (int j = 0; j < NSRC; j++) begin
      src = in_src[j*REG_W +: REG_W];
      hit = 1'b0;
      for (int k = 0; k < STAGES; k++)
        if (!hit && in_src_used[j] && src != '0 && valid[k] && we_q[k] && !flush[k] && dst_q[k] == src) begin
          hit = 1'b1;
          if (ld_q[k] && k < LOAD_READY_STAGE) stall = 1'b1;
          else fwd_sel[j*FW +: FW] = FW'(k + 1);
        end
    end
  end
  // Stage tags flattened for the datapath
  always_comb begin
    stage_dst = '0;
    for (int i = 0; i < STAGES; i++) stage_dst[i*REG_W +: REG_W] = dst_q[i];
  end
  assign to_valid     = {valid[STAGES-2:0] & stage_ready_go[STAGES-2:0] & ~flush[STAGES-2:0], in_valid & ~stall};
  assign stage_adv    = to_valid & allowin;
  assign stage_valid  = valid;
  assign stage_we     = valid & we_q;
  assign in_allowin   = allowin[0] & ~stall;
  assign retire_valid = valid[STAGES-1] & stage_ready_go[STAGES-1] & ~flush[STAGES-1] & out_allowin;
  assign occupancy    = FW'($countones(valid));
  // Occupancy: refill when the stage accepts, otherwise hold unless squashed
  always_ff @(posedge clk)
    if (reset) valid <= '0;
    else for (int i = 0; i < STAGES; i++) valid[i] <= allowin[i] ? to_valid[i] : valid[i] & ~flush[i];
  // Tags travel with their instruction; register 0 is never marked as written
  always_ff @(posedge clk) begin
    if (stage_adv[0]) begin
      dst_q[0] <= in_dst;
      we_q[0]  <= in_we && in_dst != '0;
      ld_q[0]  <= in_is_load;
    end
    for (int i = 1; i < STAGES; i++)
      if (stage_adv[i]) begin
        dst_q[i] <= dst_q[i-1];
        we_q[i]  <= we_q[i-1];
        ld_q[i]  <= ld_q[i-1];
      end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of pipe_hazard_ctrl against an instruction-slot model
module tb_pipe_hazard_ctrl;
  localparam int S = 3, RW = 5, NS = 2, LRS = 2, FW = 2;
  logic clk, reset, in_valid, in_allowin, in_we, in_is_load, out_allowin, stall, retire_valid;
  logic [RW-1:0] in_dst;
  logic [NS*RW-1:0] in_src;
  logic [NS-1:0] in_src_used;
  logic [S-1:0] stage_ready_go, flush, stage_adv, stage_valid, stage_we;
  logic [S*RW-1:0] stage_dst;
  logic [NS*FW-1:0] fwd_sel;
  logic [FW-1:0] occupancy;
  int n_assert = 0, n_fail = 0, dut_ret = 0, mdl_ret = 0, r0;
  int exp_f [3] = '{2, 3, 0};
  logic [S-1:0] m_v, m_we, m_ld;
  logic [RW-1:0] m_dst [S];
  logic [S:0] e_al;
  logic [S-1:0] e_tov, e_adv;
  logic e_stall, e_ret;
  logic [NS*FW-1:0] e_fs;

  pipe_hazard_ctrl #(.STAGES(S), .REG_W(RW), .NSRC(NS), .LOAD_READY_STAGE(LRS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_allowin(in_allowin), .in_dst(in_dst),
    .in_we(in_we), .in_is_load(in_is_load), .in_src(in_src), .in_src_used(in_src_used),
    .stage_ready_go(stage_ready_go), .flush(flush), .out_allowin(out_allowin),
    .stage_adv(stage_adv), .stage_valid(stage_valid), .stage_dst(stage_dst), .stage_we(stage_we),
    .fwd_sel(fwd_sel), .stall(stall), .retire_valid(retire_valid), .occupancy(occupancy));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected behaviour for the current slot contents and inputs
  task automatic eval();
    e_al[S] = out_allowin;
    for (int i = S - 1; i >= 0; i--) e_al[i] = !m_v[i] || flush[i] || (stage_ready_go[i] && e_al[i+1]);
    e_stall = 0;
    e_fs = '0;
    for (int j = 0; j < NS; j++) begin
      logic [RW-1:0] s;
      int hit;
      s = in_src[j*RW +: RW];
      hit = -1;
      if (in_src_used[j] && s != 0)
        for (int k = 0; k < S; k++)
          if (hit < 0 && m_v[k] && m_we[k] && !flush[k] && m_dst[k] == s) hit = k;
      if (hit >= 0) begin
        if (m_ld[hit] && hit < LRS) e_stall = 1;
        else e_fs[j*FW +: FW] = FW'(hit + 1);
      end
    end
    e_tov[0] = in_valid && !e_stall;
    for (int i = 1; i < S; i++) e_tov[i] = m_v[i-1] && stage_ready_go[i-1] && !flush[i-1];
    e_adv = e_tov & e_al[S-1:0];
    e_ret = m_v[S-1] && stage_ready_go[S-1] && !flush[S-1] && out_allowin;
  endtask

  task automatic update();
    logic [S-1:0] nv, nwe, nld;
    logic [RW-1:0] nd [S];
    for (int i = 0; i < S; i++) begin
      nv[i] = e_al[i] ? e_tov[i] : (m_v[i] && !flush[i]);
      nwe[i] = m_we[i];
      nld[i] = m_ld[i];
      nd[i] = m_dst[i];
    end
    if (e_adv[0]) begin
      nd[0] = in_dst;
      nwe[0] = in_we && in_dst != 0;
      nld[0] = in_is_load;
    end
    for (int i = 1; i < S; i++)
      if (e_adv[i]) begin
        nd[i] = m_dst[i-1];
        nwe[i] = m_we[i-1];
        nld[i] = m_ld[i-1];
      end
    if (reset) nv = '0;
    m_v = nv;
    m_we = nwe;
    m_ld = nld;
    for (int i = 0; i < S; i++) m_dst[i] = nd[i];
  endtask

  task automatic step();
    #1;
    eval();
    chk("stage_valid", 32'(stage_valid), 32'(m_v));
    chk("stage_adv", 32'(stage_adv), 32'(e_adv));
    chk("stage_we", 32'(stage_we), 32'(m_v & m_we));
    chk("in_allowin", 32'(in_allowin), 32'(e_al[0] && !e_stall));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("retire_valid", 32'(retire_valid), 32'(e_ret));
    chk("occupancy", 32'(occupancy), 32'($countones(m_v)));
    chk("fwd_sel", 32'(fwd_sel), 32'(e_fs));
    for (int i = 0; i < S; i++) if (m_v[i]) chk("stage_dst", 32'(stage_dst[i*RW +: RW]), 32'(m_dst[i]));
    dut_ret += 32'(retire_valid);
    mdl_ret += 32'(e_ret);
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; in_valid = 0; in_dst = 0; in_we = 0; in_is_load = 0;
    in_src = 0; in_src_used = 0; stage_ready_go = '1; flush = '0; out_allowin = 1;
  endtask

  task automatic ins(input logic [RW-1:0] d, input logic w, input logic l,
                     input logic [RW-1:0] s0, input logic [RW-1:0] s1, input logic [NS-1:0] u);
    in_valid = 1; in_dst = d; in_we = w; in_is_load = l; in_src = {s1, s0}; in_src_used = u;
  endtask

  initial begin
    idle();
    reset = 1;
    m_v = '0; m_we = '0; m_ld = '0;
    for (int i = 0; i < S; i++) m_dst[i] = '0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_occ", 32'(occupancy), 32'(0));
    chk("reset_allowin", 32'(in_allowin), 32'(1));
    step();
    reset = 0;
    // forwarding follows a producer down the pipe
    ins(3, 1, 0, 0, 0, 2'b00);
    step();
    ins(9, 1, 0, 3, 0, 2'b01);
    #1 chk("fwd_ex", 32'(fwd_sel[1:0]), 32'(1));
    step();
    idle();
    in_src = {5'd0, 5'd3};
    in_src_used = 2'b01;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("fwd_age", 32'(fwd_sel[1:0]), 32'(exp_f[n]));
      chk("fwd_age_stall", 32'(stall), 32'(0));
      step();
    end
    // load-use interlock
    ins(5, 1, 1, 0, 0, 2'b00);
    step();
    ins(6, 1, 0, 0, 5, 2'b10);
    #1;
    chk("lu_stall0", 32'(stall), 32'(1));
    chk("lu_allow0", 32'(in_allowin), 32'(0));
    step();
    #1 chk("lu_stall1", 32'(stall), 32'(1));
    step();
    #1;
    chk("lu_stall2", 32'(stall), 32'(0));
    chk("lu_fwd", 32'(fwd_sel[3:2]), 32'(3));
    step();
    idle();
    repeat (3) step();
    // youngest producer wins; r0 never forwards
    ins(7, 1, 0, 0, 0, 2'b00); step();
    ins(1, 1, 0, 0, 0, 2'b00); step();
    ins(7, 1, 0, 0, 0, 2'b00); step();
    idle();
    in_src = {5'd0, 5'd7};
    in_src_used = 2'b01;
    #1 chk("fwd_young", 32'(fwd_sel[1:0]), 32'(1));
    in_src = '0;
    #1 chk("fwd_r0", 32'(fwd_sel[1:0]), 32'(0));
    step();
    idle();
    repeat (3) step();
    // mid-pipe back-pressure
    for (int n = 0; n < 3; n++) begin ins(RW'(10 + n), 1, 0, 0, 0, 2'b00); step(); end
    ins(13, 1, 0, 0, 0, 2'b00);
    stage_ready_go = 3'b101;
    #1;
    chk("bp_adv0", 32'(stage_adv[0]), 32'(0));
    chk("bp_allow", 32'(in_allowin), 32'(0));
    chk("bp_retire", 32'(retire_valid), 32'(1));
    chk("bp_occ3", 32'(occupancy), 32'(3));
    step();
    #1;
    chk("bp_valid", 32'(stage_valid), 32'(3'b011));
    chk("bp_occ2", 32'(occupancy), 32'(2));
    chk("bp_retire2", 32'(retire_valid), 32'(0));
    step();
    stage_ready_go = '1;
    step();
    idle();
    repeat (4) step();
    // squash of two younger stages
    r0 = dut_ret;
    for (int n = 0; n < 3; n++) begin ins(RW'(20 + n), 1, 0, 0, 0, 2'b00); step(); end
    idle();
    out_allowin = 0;
    flush = 3'b011;
    step();
    #1;
    chk("flush_valid", 32'(stage_valid), 32'(3'b100));
    chk("flush_occ", 32'(occupancy), 32'(1));
    idle();
    repeat (4) step();
    chk("flush_retired", 32'(dut_ret - r0), 32'(1));
    // reset mid-stream
    for (int n = 0; n < 3; n++) begin ins(RW'(24 + n), 1, 0, 0, 0, 2'b00); step(); end
    ins(27, 1, 1, 0, 0, 2'b00);
    reset = 1;
    step();
    reset = 0;
    in_valid = 0;
    #1;
    chk("rst_valid", 32'(stage_valid), 32'(0));
    chk("rst_occ", 32'(occupancy), 32'(0));
    chk("rst_stall", 32'(stall), 32'(0));
    chk("rst_retire", 32'(retire_valid), 32'(0));
    ins(28, 1, 0, 0, 0, 2'b00);
    #1;
    chk("rst_issue", 32'(in_allowin), 32'(1));
    chk("rst_adv", 32'(stage_adv[0]), 32'(1));
    step();
    // random traffic
    repeat (600) begin
      in_valid = $urandom_range(0, 9) < 7;
      in_dst = RW'($urandom_range(0, 7));
      in_we = $urandom_range(0, 3) != 0;
      in_is_load = $urandom_range(0, 2) == 0;
      in_src = {RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7))};
      in_src_used = NS'($urandom_range(0, 3));
      for (int i = 0; i < S; i++) begin
        stage_ready_go[i] = $urandom_range(0, 3) != 0;
        flush[i] = $urandom_range(0, 9) == 0;
      end
      out_allowin = $urandom_range(0, 4) != 0;
      reset = $urandom_range(0, 99) == 0;
      step();
    end
    idle();
    repeat (6) step();
    chk("retire_total", 32'(dut_ret), 32'(mdl_ret));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
